// File: rtl/sdram_client_if.sv
// Host command and SDRAM controller signals of the sdram_client block.
// slave = the client itself, master = the host/controller side.
interface sdram_client_if;

    logic       host_cmd_valid;
    logic       host_cmd_ready;
    logic       host_cmd_wr;
    logic [8:0] host_cmd_len;
    logic       host_done;
    logic       host_err;
    logic       busy;

    logic       sdram_init_done;
    logic       sdram_wr_req;
    logic       sdram_rd_req;
    logic       sdram_wr_ack;
    logic       sdram_rd_ack;
    logic [8:0] sdwr_bytes;
    logic [8:0] sdrd_bytes;

    modport slave (
        input  host_cmd_valid,
        input  host_cmd_wr,
        input  host_cmd_len,
        input  sdram_init_done,
        input  sdram_wr_ack,
        input  sdram_rd_ack,
        output host_cmd_ready,
        output host_done,
        output host_err,
        output busy,
        output sdram_wr_req,
        output sdram_rd_req,
        output sdwr_bytes,
        output sdrd_bytes
    );

    modport master (
        output host_cmd_valid,
        output host_cmd_wr,
        output host_cmd_len,
        output sdram_init_done,
        output sdram_wr_ack,
        output sdram_rd_ack,
        input  host_cmd_ready,
        input  host_done,
        input  host_err,
        input  busy,
        input  sdram_wr_req,
        input  sdram_rd_req,
        input  sdwr_bytes,
        input  sdrd_bytes
    );

endinterface

// File: rtl/sdram_client.sv
// Queues host burst commands and sequences them onto an SDRAM controller.
// Define SDRAM_CLIENT_TIMEOUT_EN to add the request/ack timeout watchdog.
module sdram_client #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic           clk_100m,
    input logic           rst_n,
    sdram_client_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_REQ,
        S_ACK,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       wr;
        logic [8:0] len;
    } cmd_t;

    state_e     state_q, state_d;
    cmd_t       fifo_q [2];
    cmd_t       fifo_d [2];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] count_q, count_d;
    cmd_t       cur_q, cur_d;
    logic       wr_req_q, wr_req_d;
    logic       rd_req_q, rd_req_d;
    logic [8:0] wr_bytes_q, wr_bytes_d;
    logic [8:0] rd_bytes_q, rd_bytes_d;

    logic push;
    logic pop;
    logic match_ack;
    logic active_d;
    logic timeout;

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign bus.host_cmd_ready = (count_q != 2'd2);
    assign push = bus.host_cmd_valid && bus.host_cmd_ready;

    assign match_ack = cur_q.wr ? bus.sdram_wr_ack : bus.sdram_rd_ack;

    assign bus.host_done    = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE && state_q != S_WAIT_INIT)
                              || (count_q != 2'd0);
    assign bus.sdram_wr_req = wr_req_q;
    assign bus.sdram_rd_req = rd_req_q;
    assign bus.sdwr_bytes   = wr_bytes_q;
    assign bus.sdrd_bytes   = rd_bytes_q;

    always_comb begin
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            fifo_d[wptr_q] = '{wr: bus.host_cmd_wr, len: bus.host_cmd_len};
            wptr_d = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        unique case (1'b1)
            (push && !pop): count_d = count_q + 2'd1;
            (pop && !push): count_d = count_q - 2'd1;
            default:        count_d = count_q;
        endcase
    end

`ifdef SDRAM_CLIENT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             in_xfer;

    assign in_xfer = (state_q == S_REQ) || (state_q == S_ACK);
    assign timeout = in_xfer && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bus.host_err = err_q;

    // Idle cycles hold the counter at zero, so S_REQ always starts fresh.
    always_comb begin
        tmo_d = '0;
        err_d = timeout;
        if (in_xfer) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    // No watchdog: transfers wait for the controller indefinitely.
    assign timeout      = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign bus.host_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        unique case (state_q)
            S_WAIT_INIT: begin
                if (bus.sdram_init_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    pop   = 1'b1;
                    cur_d = fifo_q[rptr_q];
                    if (fifo_q[rptr_q].len == 9'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (match_ack) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (!match_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_WAIT_INIT;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state they belong to.
        active_d   = (state_d == S_REQ) || (state_d == S_ACK);
        wr_req_d   = (state_d == S_REQ) && cur_d.wr;
        rd_req_d   = (state_d == S_REQ) && !cur_d.wr;
        wr_bytes_d = (active_d && cur_d.wr) ? cur_d.len : 9'd0;
        rd_bytes_d = (active_d && !cur_d.wr) ? cur_d.len : 9'd0;
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_INIT;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
            cur_q      <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_bytes_q <= 9'd0;
            rd_bytes_q <= 9'd0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            wr_bytes_q <= wr_bytes_d;
            rd_bytes_q <= rd_bytes_d;
        end
    end

endmodule

// File: tb/tb_sdram_client.sv
// Scoreboard bench for sdram_client: directed commands, a controller
// responder, and a monitor comparing every request/done/err event.
module tb_sdram_client;

    localparam int K_NONE = -1;
    localparam int K_REQ  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic       wr;
        logic [8:0] len;
    } ev_t;

    logic clk_100m = 1'b0;
    logic rst_n;

    sdram_client_if bus();

    sdram_client #(.TIMEOUT_CYCLES(64)) dut (
        .clk_100m(clk_100m),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_100m = ~clk_100m;

    ev_t  exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   auto_en  = 1'b0;
    logic p_wr     = 1'b0;
    logic p_rd     = 1'b0;
    logic p_done   = 1'b0;
    logic p_err    = 1'b0;
    logic resp_wr;
    int   n_high;
    bit   ok;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic w,
                             input logic [8:0] l);
        ev_t e;
        e.kind = kind;
        e.wr   = w;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    // Offer one command for one edge; queue the expected events if accepted.
    task automatic push(input logic w, input logic [8:0] l,
                        input logic exp_ready, input int tail);
        bus.host_cmd_valid = 1'b1;
        bus.host_cmd_wr    = w;
        bus.host_cmd_len   = l;
        chk("ready_at_push", bus.host_cmd_ready, exp_ready);
        @(posedge clk_100m);
        #1;
        bus.host_cmd_valid = 1'b0;
        if (exp_ready) begin
            if (l != 9'd0) expect_ev(K_REQ, w, l);
            if (tail != K_NONE) expect_ev(tail, w, l);
        end
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_100m);
            if (bus.sdram_wr_req || bus.sdram_rd_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_within_budget", seen, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_100m);
            if (!bus.busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk("idle_within_budget", idle, 1'b1);
    endtask

    task automatic take(input int kind, input logic w, input logic [8:0] l,
                        input logic [8:0] other);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d required=none",
                     kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == K_REQ) begin
                chk("req_type", w, e.wr);
                chk("req_bytes", l, e.len);
                chk("other_bytes_zero", other, 9'd0);
            end
        end
    endtask

    always @(negedge clk_100m) begin
        if (bus.sdram_wr_req && !p_wr)
            take(K_REQ, 1'b1, bus.sdwr_bytes, bus.sdrd_bytes);
        if (bus.sdram_rd_req && !p_rd)
            take(K_REQ, 1'b0, bus.sdrd_bytes, bus.sdwr_bytes);
        if (bus.host_done) begin
            chk("done_single_cycle", p_done, 1'b0);
            take(K_DONE, 1'b0, 9'd0, 9'd0);
        end
        if (bus.host_err) begin
            chk("err_single_cycle", p_err, 1'b0);
            take(K_ERR, 1'b0, 9'd0, 9'd0);
        end
        if (bus.sdram_wr_req || bus.sdram_rd_req)
            chk("req_overlap", bus.sdram_wr_req & bus.sdram_rd_req, 1'b0);
        p_wr   = bus.sdram_wr_req;
        p_rd   = bus.sdram_rd_req;
        p_done = bus.host_done;
        p_err  = bus.host_err;
    end

    // Controller model: ack 3 cycles after a request, hold it 4 cycles.
    initial begin
        forever begin
            @(negedge clk_100m);
            if (auto_en && (bus.sdram_wr_req || bus.sdram_rd_req)) begin
                resp_wr = bus.sdram_wr_req;
                repeat (3) @(posedge clk_100m);
                #1;
                if (resp_wr) bus.sdram_wr_ack = 1'b1;
                else         bus.sdram_rd_ack = 1'b1;
                @(posedge clk_100m);
                #1;
                chk("req_drop_after_ack",
                    resp_wr ? bus.sdram_wr_req : bus.sdram_rd_req, 1'b0);
                repeat (3) @(posedge clk_100m);
                #1;
                bus.sdram_wr_ack = 1'b0;
                bus.sdram_rd_ack = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n                = 1'b1;
        bus.host_cmd_valid   = 1'b0;
        bus.host_cmd_wr      = 1'b0;
        bus.host_cmd_len     = 9'd0;
        bus.sdram_init_done  = 1'b0;
        bus.sdram_wr_ack     = 1'b0;
        bus.sdram_rd_ack     = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_wr_req", bus.sdram_wr_req, 1'b0);
        chk("rst_rd_req", bus.sdram_rd_req, 1'b0);
        chk("rst_wr_bytes", bus.sdwr_bytes, 9'd0);
        chk("rst_rd_bytes", bus.sdrd_bytes, 9'd0);
        chk("rst_done", bus.host_done, 1'b0);
        chk("rst_err", bus.host_err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.host_cmd_ready, 1'b1);
        repeat (2) @(negedge clk_100m);
        rst_n   = 1'b1;
        auto_en = 1'b1;

        // Single write after init
        repeat (10) @(posedge clk_100m);
        #1;
        bus.sdram_init_done = 1'b1;
        repeat (3) @(posedge clk_100m);
        #1;
        push(1'b1, 9'd16, 1'b1, K_DONE);
        chk("busy_after_push", bus.busy, 1'b1);
        @(posedge clk_100m);
        #1;
        chk("wr_req_latency", bus.sdram_wr_req, 1'b1);
        chk("wr_bytes_16", bus.sdwr_bytes, 9'd16);
        wait_idle();

        // Back-to-back read then write
        push(1'b0, 9'd8, 1'b1, K_DONE);
        push(1'b1, 9'd4, 1'b1, K_DONE);
        wait_idle();

        // Foreign rd_ack during a write, max length
        auto_en = 1'b0;
        push(1'b1, 9'd511, 1'b1, K_DONE);
        wait_req(ok);
        bus.sdram_rd_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_100m);
            #1;
            chk("wr_req_ignores_rd_ack", bus.sdram_wr_req, 1'b1);
            chk("wr_bytes_511", bus.sdwr_bytes, 9'd511);
        end
        bus.sdram_rd_ack = 1'b0;
        bus.sdram_wr_ack = 1'b1;
        @(posedge clk_100m);
        #1;
        chk("wr_req_drop", bus.sdram_wr_req, 1'b0);
        chk("wr_bytes_in_ack", bus.sdwr_bytes, 9'd511);
        bus.sdram_wr_ack = 1'b0;
        wait_idle();

        // No ack from controller
`ifdef SDRAM_CLIENT_TIMEOUT_EN
        push(1'b0, 9'd33, 1'b1, K_ERR);
        wait_req(ok);
        n_high = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.sdram_rd_req) break;
            n_high++;
            @(negedge clk_100m);
        end
        chk("timeout_req_cycles", n_high, 64);
        wait_idle();
        auto_en = 1'b1;
        push(1'b1, 9'd2, 1'b1, K_DONE);
        wait_idle();
`else
        push(1'b0, 9'd33, 1'b1, K_DONE);
        wait_req(ok);
        n_high = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.sdram_rd_req) n_high++;
            @(negedge clk_100m);
        end
        chk("req_held_no_timeout", n_high, 200);
        bus.sdram_rd_ack = 1'b1;
        @(posedge clk_100m);
        #1;
        chk("rd_req_drop", bus.sdram_rd_req, 1'b0);
        bus.sdram_rd_ack = 1'b0;
        wait_idle();
        auto_en = 1'b1;
`endif

        // Reset while in S_ACK
        auto_en = 1'b0;
        push(1'b1, 9'd9, 1'b1, K_NONE);
        wait_req(ok);
        bus.sdram_wr_ack = 1'b1;
        @(posedge clk_100m);
        #1;
        chk("ack_state_bytes", bus.sdwr_bytes, 9'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_req", bus.sdram_wr_req, 1'b0);
        chk("mid_rst_wr_bytes", bus.sdwr_bytes, 9'd0);
        chk("mid_rst_done", bus.host_done, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ready", bus.host_cmd_ready, 1'b1);
        bus.sdram_wr_ack    = 1'b0;
        bus.sdram_init_done = 1'b0;
        repeat (3) @(negedge clk_100m);
        rst_n = 1'b1;
        @(posedge clk_100m);
        #1;
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_ready", bus.host_cmd_ready, 1'b1);

        // Queue fills before init; zero-length command
        auto_en = 1'b1;
        push(1'b1, 9'd20, 1'b1, K_DONE);
        push(1'b0, 9'd0, 1'b1, K_DONE);
        push(1'b1, 9'd7, 1'b0, K_DONE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100m);
            chk("no_req_before_init",
                bus.sdram_wr_req | bus.sdram_rd_req, 1'b0);
        end
        chk("full_ready_low", bus.host_cmd_ready, 1'b0);
        chk("busy_waiting_init", bus.busy, 1'b1);
        bus.sdram_init_done = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk_100m);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
